// File: rtl/spi_pkg.sv
// Shared definitions for the SPI read-frame master and consumers of its frames.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  // System clocks per SCLK half-period.
  localparam int unsigned SPI_CLK_DIV   = 2;
  // Bits per read frame.
  localparam int unsigned SPI_DATA_BITS = 32;

endpackage

// File: rtl/spi_rx_master_if.sv
// Request, serial and frame-output signals of the SPI read master.
interface spi_rx_master_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_BITS = SPI_DATA_BITS
) ();

  logic                 spi_ena;
  logic                 miso;
  logic                 sclk;
  logic                 cs_n;
  logic                 spi_not_busy;
  logic [DATA_BITS-1:0] spi_rx_data;

  modport master (
    input  spi_ena,
    input  miso,
    output sclk,
    output cs_n,
    output spi_not_busy,
    output spi_rx_data
  );

  modport slave (
    output spi_ena,
    output miso,
    input  sclk,
    input  cs_n,
    input  spi_not_busy,
    input  spi_rx_data
  );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period timer: paces every phase of a frame and strobes the sclk edges.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,      // frame in progress (any non-idle state)
  input  logic shift,   // sclk is running
  input  logic sclk,    // current registered sclk level
  output logic tick,    // last cycle of the current half-period
  output logic toggle,  // sclk flips on the coming edge
  output logic rise     // sclk goes 0->1 on the coming edge
);

  localparam int unsigned          CNT_W    = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count half-period cycles; restart at every phase boundary and when idle.
  always_comb begin
    tick   = en && (cnt_q == CNT_LAST);
    toggle = tick && shift;
    rise   = toggle && !sclk;
    cnt_d  = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_rx_master.sv
// SPI mode-0 read master: one DATA_BITS frame per request, result published
// atomically when the frame closes.
module spi_rx_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV   = SPI_CLK_DIV,
  parameter int unsigned DATA_BITS = SPI_DATA_BITS
) (
  input  logic            clk,
  input  logic            rst,
  spi_rx_master_if.master bus
);

  localparam int unsigned      BIT_W    = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  spi_state_e           state_q, state_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 not_busy_q, not_busy_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic                 run;
  logic                 shifting;
  logic                 tick;
  logic                 toggle;
  logic                 rise;

  assign run      = (state_q != IDLE);
  assign shifting = (state_q == SHIFT);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .shift  (shifting),
    .sclk   (sclk_q),
    .tick   (tick),
    .toggle (toggle),
    .rise   (rise)
  );

  // Next-state logic; outputs are computed one cycle ahead so they leave flops.
  always_comb begin
    state_d    = state_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    not_busy_d = not_busy_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    rx_d       = rx_q;
    case (state_q)
      IDLE: begin
        if (bus.spi_ena) begin
          state_d    = SETUP;
          cs_n_d     = 1'b0;
          not_busy_d = 1'b0;
          bit_d      = '0;
          shreg_d    = '0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (toggle) begin
          sclk_d = ~sclk_q;
        end
        if (rise) begin
          shreg_d = {shreg_q[DATA_BITS-2:0], bus.miso};
        end
        // Falling edge: one more bit complete; the last one ends the shift phase.
        if (toggle && sclk_q) begin
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d    = IDLE;
          cs_n_d     = 1'b1;
          not_busy_d = 1'b1;
          rx_d       = shreg_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over any pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      not_busy_q <= 1'b1;
      bit_q      <= '0;
      shreg_q    <= '0;
      rx_q       <= '0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      not_busy_q <= not_busy_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      rx_q       <= rx_d;
    end
  end

  assign bus.sclk         = sclk_q;
  assign bus.cs_n         = cs_n_q;
  assign bus.spi_not_busy = not_busy_q;
  assign bus.spi_rx_data  = rx_q;

endmodule

// File: tb/tb_spi_rx_master.sv
// Bench for spi_rx_master: default instance plus a CLK_DIV=1 / DATA_BITS=8 instance.
module tb_spi_rx_master;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  spi_rx_master_if                  bus0 ();
  spi_rx_master_if #(.DATA_BITS(8)) bus1 ();

  spi_rx_master u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  spi_rx_master #(
    .CLK_DIV   (1),
    .DATA_BITS (8)
  ) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [31:0] data;
    int          busy;
    int          rises;
  } exp_t;

  exp_t        exp0[$];
  exp_t        exp1[$];
  logic [31:0] sq0[$];
  logic [31:0] sq1[$];
  exp_t        e0;
  exp_t        e1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  // Slave model + monitor for the default instance (sampled 1 ns after the edge).
  int          busy0 = 0, rises0 = 0, frames0 = 0, csn_run0 = 0, last_gap0 = 0, idx0;
  logic        sclk_prev0 = 1'b0, act0 = 1'b0;
  logic [31:0] cur0 = '0, last_rx0 = '0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy0      = 0;
      rises0     = 0;
      act0       = 1'b0;
      sclk_prev0 = 1'b0;
      last_rx0   = '0;
      bus0.miso  = 1'b0;
    end else begin
      if (bus0.spi_not_busy !== 1'b1) begin
        busy0++;
        check("rx_hold", bus0.spi_rx_data, last_rx0);
      end else if (busy0 > 0) begin
        frames0++;
        last_rx0 = bus0.spi_rx_data;
        check("sb0_pending", 32'(exp0.size() > 0), 32'd1);
        if (exp0.size() > 0) begin
          e0 = exp0.pop_front();
          check("rx_data", bus0.spi_rx_data, e0.data);
          check("busy_len", busy0, e0.busy);
          check("sclk_rises", rises0, e0.rises);
        end
        busy0 = 0;
      end
      if (bus0.cs_n) begin
        act0   = 1'b0;
        rises0 = 0;
        csn_run0++;
      end else begin
        if (csn_run0 > 0) begin
          last_gap0 = csn_run0;
          csn_run0  = 0;
        end
        if (!act0) begin
          act0 = 1'b1;
          cur0 = (sq0.size() > 0) ? sq0.pop_front() : 32'h0;
        end
        if (bus0.sclk && !sclk_prev0) rises0++;
      end
      sclk_prev0 = bus0.sclk;
      idx0 = 31 - rises0;
      if (idx0 < 0) idx0 = 0;
      bus0.miso = cur0[idx0];
    end
  end

  // Slave model + monitor for the 8-bit, CLK_DIV=1 instance.
  int          busy1 = 0, rises1 = 0, frames1 = 0, cyc1 = 0, last_rise1 = 0, period1 = 0, idx1;
  logic        sclk_prev1 = 1'b0, act1 = 1'b0;
  logic [31:0] cur1 = '0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy1      = 0;
      rises1     = 0;
      act1       = 1'b0;
      sclk_prev1 = 1'b0;
      bus1.miso  = 1'b0;
    end else begin
      cyc1++;
      if (bus1.spi_not_busy !== 1'b1) begin
        busy1++;
      end else if (busy1 > 0) begin
        frames1++;
        check("sb1_pending", 32'(exp1.size() > 0), 32'd1);
        if (exp1.size() > 0) begin
          e1 = exp1.pop_front();
          check("rx_data8", 32'(bus1.spi_rx_data), e1.data);
          check("busy_len8", busy1, e1.busy);
          check("sclk_rises8", rises1, e1.rises);
        end
        busy1 = 0;
      end
      if (bus1.cs_n) begin
        act1   = 1'b0;
        rises1 = 0;
      end else begin
        if (!act1) begin
          act1 = 1'b1;
          cur1 = (sq1.size() > 0) ? sq1.pop_front() : 32'h0;
        end
        if (bus1.sclk && !sclk_prev1) begin
          if (rises1 > 0) period1 = cyc1 - last_rise1;
          last_rise1 = cyc1;
          rises1++;
        end
      end
      sclk_prev1 = bus1.sclk;
      idx1 = 7 - rises1;
      if (idx1 < 0) idx1 = 0;
      bus1.miso = cur1[idx1];
    end
  end

  task automatic push0(input logic [31:0] w);
    exp_t e;
    e.data  = w;
    e.busy  = 132;
    e.rises = 32;
    sq0.push_back(w);
    exp0.push_back(e);
  endtask

  task automatic pulse0();
    @(negedge clk);
    bus0.spi_ena = 1'b1;
    @(negedge clk);
    bus0.spi_ena = 1'b0;
  endtask

  task automatic wait_frame0(input int target);
    int t = 0;
    while (frames0 < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("frame_done", frames0, target);
  endtask

  task automatic wait_rises0(input int n);
    int t = 0;
    while (rises0 < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("rise_reached", 32'(rises0 >= n), 32'd1);
  endtask

  initial begin
    exp_t e;
    int   t;
    bus0.spi_ena = 1'b1;
    bus1.spi_ena = 1'b1;

    // Reset with spi_ena held high: outputs idle, request ignored.
    repeat (3) @(negedge clk);
    check("rst_cs_n", bus0.cs_n, 1);
    check("rst_sclk", bus0.sclk, 0);
    check("rst_not_busy", bus0.spi_not_busy, 1);
    check("rst_rx", bus0.spi_rx_data, 0);
    check("rst_rx8", 32'(bus1.spi_rx_data), 0);

    // Nominal frame, started on the first cycle after reset release.
    push0(32'h12345678);
    rst = 1'b0;
    bus1.spi_ena = 1'b0;
    @(negedge clk);
    bus0.spi_ena = 1'b0;
    check("start_after_rst", bus0.spi_not_busy, 0);
    wait_frame0(1);

    // Thermocouple-style frame.
    push0(32'h01901A40);
    pulse0();
    wait_frame0(2);
    check("tc_temp", 32'(last_rx0[31:18]), 32'h0064);
    check("tc_cj", 32'(last_rx0[15:4]), 32'h01A4);

    // Back-to-back with spi_ena held high.
    push0(32'hAAAAAAAA);
    push0(32'h55555555);
    @(negedge clk);
    bus0.spi_ena = 1'b1;
    wait_frame0(3);
    t = 0;
    while (bus0.spi_not_busy && t < 10) begin
      @(negedge clk);
      t++;
    end
    bus0.spi_ena = 1'b0;
    wait_frame0(4);
    check("b2b_gap", last_gap0, 1);

    // Abort during bit 10, then a clean frame.
    sq0.push_back(32'h0F0F0F0F);
    pulse0();
    wait_rises0(10);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs_n", bus0.cs_n, 1);
    check("abort_sclk", bus0.sclk, 0);
    check("abort_not_busy", bus0.spi_not_busy, 1);
    check("abort_rx", bus0.spi_rx_data, 0);
    rst = 1'b0;
    push0(32'hDEADBEEF);
    pulse0();
    wait_frame0(5);

    // Request pulsed mid-frame is dropped.
    push0(32'h3C5A9617);
    pulse0();
    wait_rises0(5);
    pulse0();
    wait_frame0(6);
    repeat (200) @(negedge clk);
    check("no_extra_frame", frames0, 6);
    check("sb0_empty", 32'(exp0.size()), 0);

    // Parameter corner: CLK_DIV=1, DATA_BITS=8.
    e.data  = 32'h000000A5;
    e.busy  = 18;
    e.rises = 8;
    sq1.push_back(32'h000000A5);
    exp1.push_back(e);
    @(negedge clk);
    bus1.spi_ena = 1'b1;
    @(negedge clk);
    bus1.spi_ena = 1'b0;
    t = 0;
    while (frames1 < 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("frame_done8", frames1, 1);
    check("sclk_period8", period1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_rx_master.md
SPI_RX_MASTER -- requirements
Module: spi_rx_master

Interface
REQ-001 Parameter: CLK_DIV, 2, system clocks per SCLK half-period; legal range 1..255.
REQ-002 Parameter: DATA_BITS, 32, bits per read frame; legal range 8..32.
REQ-003 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: spi_ena  input  1  transaction request; level-sampled, no edge detection.
REQ-006 Port: miso  input  1  serial data from the sensor; MSB first.
REQ-007 Port: sclk  output  1  SPI clock; CPOL=0, CPHA=0.
REQ-008 Port: cs_n  output  1  active-low chip select.
REQ-009 Port: spi_not_busy  output  1  high when idle and able to accept spi_ena.
REQ-010 Port: spi_rx_data  output  DATA_BITS  last completed frame; bit DATA_BITS-1 is the first bit received.

Function
REQ-011 States: IDLE, SETUP, SHIFT, HOLD; the block SHALL use no other states.
REQ-012 IDLE: cs_n=1, sclk=0, spi_not_busy=1; spi_ena=1 moves the block to SETUP on the next edge.
REQ-013 SETUP: cs_n=0, sclk=0, spi_not_busy=0 for exactly CLK_DIV cycles, then SHIFT.
REQ-014 SHIFT: sclk toggles every CLK_DIV cycles, starting low, for exactly DATA_BITS full periods.
REQ-015 miso is sampled into an internal shift register on the clk edge where sclk goes 0->1, shifting left, LSB in.
REQ-016 After the DATA_BITS-th falling sclk edge, HOLD: sclk=0, cs_n=0 for CLK_DIV cycles, then IDLE.
REQ-017 On entry to IDLE, cs_n=1, spi_not_busy=1, and spi_rx_data takes the shift register value, all in the same cycle.
REQ-018 spi_rx_data SHALL hold its value for the whole transaction; no partial frames are ever visible.
REQ-019 spi_not_busy SHALL be low for exactly (2*DATA_BITS+2)*CLK_DIV consecutive cycles per transaction (132 at defaults).
REQ-020 spi_ena while busy SHALL be ignored; no queuing.
REQ-021 spi_ena held high SHALL start the next transaction after exactly one IDLE cycle with cs_n=1.
REQ-022 The sclk half-period counter SHALL be ceil(log2(CLK_DIV+1)) bits wide and the bit counter ceil(log2(DATA_BITS+1)) bits wide; neither counter wraps mid-frame.
REQ-023 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-024 rst=1 SHALL force IDLE, cs_n=1, sclk=0, spi_not_busy=1, spi_rx_data=0, and clear all counters and the shift register, regardless of state.
REQ-025 A reset during SHIFT SHALL abort the frame, with no update to spi_rx_data other than clearing it to 0.
REQ-026 spi_ena asserted in the same cycle as rst SHALL be ignored; the first transaction can start on the cycle after rst deasserts.

Structure
REQ-027 A shared package spi_pkg SHALL hold the state enum and the default CLK_DIV and DATA_BITS constants, for reuse by consumers of the read frame.
REQ-028 One sub-module, spi_clk_div, SHALL generate the sclk toggle and rising-edge strobes from CLK_DIV; all other logic stays in spi_rx_master.

Verification
REQ-029 Directed scenario, nominal frame: defaults, model drives 0x12345678, one-cycle spi_ena pulse -> spi_rx_data=0x12345678, busy exactly 132 cycles, 32 sclk rising edges.
REQ-030 Directed scenario, thermocouple frame: model drives 0x01901A40 -> spi_rx_data[31:18]=0x0064 and [15:4]=0x1A4 on the cycle spi_not_busy rises.
REQ-031 Directed scenario, back-to-back: spi_ena held high, frames 0xAAAAAAAA then 0x55555555 -> exactly one cs_n-high cycle between frames, and both values captured in order.
REQ-032 Directed scenario, abort: rst pulsed during bit 10 -> next cycle cs_n=1, sclk=0, spi_not_busy=1, spi_rx_data=0; the following frame 0xDEADBEEF reads correctly.
REQ-033 Directed scenario, ignored request: spi_ena pulsed mid-frame -> no extra transaction and the busy count is still 132.
REQ-034 Directed scenario, parameter corner: CLK_DIV=1, DATA_BITS=8, frame 0xA5 -> spi_rx_data=0x000000A5, busy 18 cycles, sclk period 2 clks.
